regfile_mp_sb: RTL and testbench

//  Parametrised multi-read-port integer register file for the pipelined core.
//  - Register 0 is hardwired to zero.
//  - Optional write-to-read bypass.
//  - Per-register scoreboard (pending-write bits).
//  - Hardware clear sequencer that zeroes the array after reset or on request.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_mp_sb_if.sv | 41 ++++
 rtl/regfile_clear_seq.sv | 71 +++++++
 rtl/regfile_mp_sb.sv | 104 ++++++++++
 tb/tb_regfile_mp_sb.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-read-port register file:
//   state_t     - clear-sequencer states (ST_IDLE, ST_SWEEP)
//   ZERO_REG    - index of the hardwired-zero register
//   addr_width  - number of index bits needed to address n registers
// ----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam int ZERO_REG = 0;

  // Elaboration-time ceil(log2(n)); n is a power of two, so this is exact.
  function automatic int addr_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb_if
// Bundle of the register-file bus between decode/writeback and the array.
//   wr_en/wr_addr/wr_data/wr_ready : writeback port (accepted on en & ready)
//   rd_addr/rd_data/rd_busy        : NRD packed read ports, port i at i*AW/i*XLEN
//   iss_en/iss_addr                : issue, marks a destination as pending
//   clr_req/clr_busy               : clear sweep request and status
// master = decode/writeback side, slave = the register file.
// ----------------------------------------------------------------------------
interface regfile_mp_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  import regfile_pkg::*;

  localparam int AW = addr_width(NREGS);

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                wr_ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                clr_req;
  logic                clr_busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, clr_req,
    input  wr_ready, rd_data, rd_busy, clr_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, clr_req,
    output wr_ready, rd_data, rd_busy, clr_busy
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// ----------------------------------------------------------------------------
// regfile_clear_seq
// Clear sequencer: walks registers 1..NREGS-1 writing zero, one per cycle.
// Starts sweeping out of reset and again on each clr_req seen while idle.
//   clk, rst      : clock, async active-high reset (restarts the sweep)
//   clr_req       : start a sweep (ignored while one is running)
//   sweep_we      : write zero to sweep_addr this cycle
//   sweep_addr    : register being zeroed
//   busy          : sweep in progress
// ----------------------------------------------------------------------------
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr,
  output logic          busy
);

  localparam logic [AW-1:0] FIRST = AW'(1);
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_SWEEP;
      cnt   <= FIRST;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Register 0 is never touched, so a sweep is NREGS-1 cycles long.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_SWEEP;
          cnt_nxt   = FIRST;
        end
      end
      ST_SWEEP: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == LAST) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_SWEEP;
        cnt_nxt   = FIRST;
      end
    endcase
  end

  always_comb begin
    sweep_we   = (state == ST_SWEEP);
    sweep_addr = cnt;
    busy       = (state == ST_SWEEP);
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb
// Multi-read-port integer register file with pending-write scoreboard.
//   clk, rst : clock, async active-high reset
//   bus      : regfile_mp_sb_if slave port (write, NRD reads, issue, clear)
// Register 0 reads as zero. With BYPASS=1 an accepted write is forwarded to
// matching read ports in the same cycle. The array itself has no reset; the
// clear sequencer zeroes it after reset and on clr_req, and reads are forced
// to zero while the sweep runs so the stale contents are never visible.
// ----------------------------------------------------------------------------
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic            clk,
  input logic            rst,
  regfile_mp_sb_if.slave bus
);

  localparam int            AW     = addr_width(NREGS);
  localparam logic [AW-1:0] R0     = AW'(ZERO_REG);
  localparam bit            USE_BP = (BYPASS != 0);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;

  logic          sweep_we;
  logic [AW-1:0] sweep_addr;
  logic          sweep_busy;
  logic          wr_acc;
  logic          clr_start;

  regfile_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (bus.clr_req),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .busy       (sweep_busy)
  );

  assign bus.wr_ready = ~sweep_busy;
  assign bus.clr_busy = sweep_busy;
  assign wr_acc       = bus.wr_en & ~sweep_busy;
  assign clr_start    = bus.clr_req & ~sweep_busy;

  // Sweep and external writes never collide: writes are refused mid-sweep.
  // A write accepted alongside clr_req lands first and is zeroed by the sweep.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (wr_acc && bus.wr_addr != R0) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Issue is applied after the write-clear so a same-cycle issue wins.
  always_comb begin
    pend_nxt = pend;
    if (wr_acc) pend_nxt[bus.wr_addr] = 1'b0;
    if (bus.iss_en && !sweep_busy) pend_nxt[bus.iss_addr] = 1'b1;
    if (sweep_busy || clr_start) pend_nxt = '0;
    pend_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          wr_hit;
    logic          iss_hit;

    assign ra      = bus.rd_addr[i*AW +: AW];
    assign wr_hit  = USE_BP && wr_acc && (bus.wr_addr == ra);
    assign iss_hit = bus.iss_en && (bus.iss_addr == ra);

    assign bus.rd_data[i*XLEN +: XLEN] =
      (sweep_busy || ra == R0) ? '0 :
      wr_hit                   ? bus.wr_data :
                                 mem[ra];

    // A write landing this cycle retires the pending bit early, unless a
    // new instruction claims the same destination in the same cycle.
    assign bus.rd_busy[i] =
      sweep_busy           ? 1'b0 :
      (wr_hit && !iss_hit) ? 1'b0 :
                             pend[ra];
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Drives one bypassing and one non-bypassing register file with the same
// directed stimulus and checks both every cycle against a behavioural model,
// plus hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [9:0]    rd_addr;
  logic          iss_en;
  logic [AW-1:0] iss_addr;
  logic          clr_req;

  int checks = 0;
  int errors = 0;

  logic        s_busy;
  logic [63:0] s_rd_byp;
  logic [63:0] s_rd_nob;
  logic [1:0]  s_rb_byp;
  logic [1:0]  s_rb_nob;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_byp ();
  regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_nob ();

  assign bus_byp.wr_en    = wr_en;
  assign bus_byp.wr_addr  = wr_addr;
  assign bus_byp.wr_data  = wr_data;
  assign bus_byp.rd_addr  = rd_addr;
  assign bus_byp.iss_en   = iss_en;
  assign bus_byp.iss_addr = iss_addr;
  assign bus_byp.clr_req  = clr_req;
  assign bus_nob.wr_en    = wr_en;
  assign bus_nob.wr_addr  = wr_addr;
  assign bus_nob.wr_data  = wr_data;
  assign bus_nob.rd_addr  = rd_addr;
  assign bus_nob.iss_en   = iss_en;
  assign bus_nob.iss_addr = iss_addr;
  assign bus_nob.clr_req  = clr_req;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_byp (
    .clk (clk),
    .rst (rst),
    .bus (bus_byp)
  );

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nob (
    .clk (clk),
    .rst (rst),
    .bus (bus_nob)
  );

  // Behavioural model: a clear is modelled as an instant wipe plus a count of
  // remaining busy cycles, since nothing is visible or writable meanwhile.
  logic [31:0] m_mem [NREGS];
  bit          m_pend [NREGS];
  int          m_sweep_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sweep_left = NREGS - 1;
      for (int i = 0; i < NREGS; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else if (m_sweep_left > 0) begin
      m_sweep_left = m_sweep_left - 1;
    end else begin
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (wr_en) m_pend[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      if (clr_req) begin
        m_sweep_left = NREGS - 1;
        for (int i = 0; i < NREGS; i++) begin
          m_mem[i]  = '0;
          m_pend[i] = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (m_sweep_left > 0 || a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (m_sweep_left > 0 || a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a && !(iss_en && iss_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [AW-1:0] a;
    if (rst) return;
    check_output("clr_busy_byp", 32'(bus_byp.clr_busy), 32'(m_sweep_left > 0));
    check_output("wr_ready_byp", 32'(bus_byp.wr_ready), 32'(m_sweep_left == 0));
    check_output("clr_busy_nob", 32'(bus_nob.clr_busy), 32'(m_sweep_left > 0));
    check_output("wr_ready_nob", 32'(bus_nob.wr_ready), 32'(m_sweep_left == 0));
    for (int p = 0; p < NRD; p++) begin
      a = rd_addr[p*AW +: AW];
      check_output($sformatf("rd_data%0d_byp", p), bus_byp.rd_data[p*32 +: 32], exp_data(a, 1'b1));
      check_output($sformatf("rd_data%0d_nob", p), bus_nob.rd_data[p*32 +: 32], exp_data(a, 1'b0));
      check_output($sformatf("rd_busy%0d_byp", p), 32'(bus_byp.rd_busy[p]), 32'(exp_busy(a, 1'b1)));
      check_output($sformatf("rd_busy%0d_nob", p), 32'(bus_nob.rd_busy[p]), 32'(exp_busy(a, 1'b0)));
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [AW-1:0] ia, input logic cr,
                                input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = ia;
    clr_req  = cr;
    rd_addr  = {ra1, ra0};
  endtask

  // One cycle: compare and sample at the falling edge, return just after rise.
  task automatic tick();
    @(negedge clk);
    compare_all();
    s_busy   = bus_byp.clr_busy;
    s_rd_byp = bus_byp.rd_data;
    s_rd_nob = bus_nob.rd_data;
    s_rb_byp = bus_byp.rd_busy;
    s_rb_nob = bus_nob.rd_busy;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (s_busy) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    int k;
    logic [63:0] acc_data;
    logic [1:0]  acc_busy;

    apply_stimulus(0, 0, 0, 0, 0, 0, 5, 31);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_clr_busy", 32'(bus_byp.clr_busy), 32'd1);
    check_output("rst_wr_ready", 32'(bus_byp.wr_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_sweep(n);
    check_output("init_sweep_len", 32'(n), 32'd31);

    // Basic write then read, and writes to register 0 discarded.
    apply_stimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 5, 5);
    tick();
    check_output("rd_reg5_byp", s_rd_byp[31:0], 32'hDEADBEEF);
    check_output("rd_reg5_nob", s_rd_nob[63:32], 32'hDEADBEEF);
    apply_stimulus(1, 0, 32'h00001234, 0, 0, 0, 0, 0);
    tick();
    check_output("rd_reg0_wr_cycle", s_rd_byp[31:0], 32'h0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5);
    tick();
    check_output("rd_reg0_after", s_rd_byp[31:0], 32'h0);

    // Bypass versus no bypass on port 1.
    apply_stimulus(1, 7, 32'hA5A5A5A5, 0, 0, 0, 5, 7);
    tick();
    check_output("byp_same_cycle", s_rd_byp[63:32], 32'hA5A5A5A5);
    check_output("nob_same_cycle", s_rd_nob[63:32], 32'h0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 5, 7);
    tick();
    check_output("nob_next_cycle", s_rd_nob[63:32], 32'hA5A5A5A5);

    // Scoreboard set, clear, and set-wins.
    apply_stimulus(0, 0, 0, 1, 9, 0, 9, 9);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 9, 9);
    tick();
    check_output("busy_after_issue", 32'(s_rb_byp[0]), 32'd1);
    apply_stimulus(1, 9, 32'd99, 0, 0, 0, 9, 9);
    tick();
    check_output("busy_wr_cycle_byp", 32'(s_rb_byp[0]), 32'd0);
    check_output("busy_wr_cycle_nob", 32'(s_rb_nob[0]), 32'd1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 9, 9);
    tick();
    check_output("busy_after_write", 32'(s_rb_byp[1]), 32'd0);
    apply_stimulus(1, 9, 32'd77, 1, 9, 0, 9, 9);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 9, 9);
    tick();
    check_output("busy_issue_and_write", 32'(s_rb_byp[0]), 32'd1);
    check_output("data_issue_and_write", s_rd_nob[31:0], 32'd77);

    // Fill every register, mark some pending, then clear with a racing write.
    for (int a = 1; a < NREGS; a++) begin
      apply_stimulus(1, AW'(a), 32'h10000000 + 32'(a) * 32'h0101, (a % 4) == 0, AW'(a), 0,
                     AW'(a), AW'(NREGS - a));
      tick();
    end
    apply_stimulus(1, 3, 32'hCAFEF00D, 0, 0, 1, 3, 8);
    tick();
    check_output("clr_pulse_byp_read", s_rd_byp[31:0], 32'hCAFEF00D);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1, 4, 32'hFFFFFFFF, 1, 6, 0, 4, 6);
      tick();
      if (s_busy) k++;
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 4, 6);
    wait_sweep(n);
    check_output("clr_sweep_len", 32'(k + n), 32'd31);
    acc_data = '0;
    acc_busy = '0;
    for (int a = 1; a < NREGS; a++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, AW'(a), AW'(NREGS - a));
      tick();
      acc_data = acc_data | s_rd_byp | s_rd_nob;
      acc_busy = acc_busy | s_rb_byp | s_rb_nob;
    end
    check_output("post_clr_data_or", acc_data[31:0] | acc_data[63:32], 32'h0);
    check_output("post_clr_busy_or", 32'(acc_busy), 32'h0);

    // Reset in the middle of a sweep restarts it.
    apply_stimulus(1, 5, 32'h0BADF00D, 1, 12, 0, 12, 5);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 1, 12, 5);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 12, 5);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_clr_busy", 32'(bus_byp.clr_busy), 32'd1);
    check_output("mid_rst_wr_ready", 32'(bus_nob.wr_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_sweep(n);
    check_output("restart_sweep_len", 32'(n), 32'd31);
    tick();
    check_output("rst_clears_pend", 32'(s_rb_byp[0]), 32'd0);
    check_output("rst_clears_data", s_rd_byp[63:32], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
